// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin bus arbiter.
package arb_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      BUSY    = 3'd1,
      WAIT    = 3'd2,
      FREE    = 3'd3,
      TIMEOUT = 3'd4
   } arb_state_t;

   localparam int TOUT_CYCLES_DEF = 3;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: first set request after ptr, wrapping modulo N.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 valid,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);
   localparam logic [IW:0] NW = (IW+1)'(N);

   logic [2*N-1:0] w_dbl;
   logic [2*N-1:0] w_rot;
   logic [IW:0]    w_shift;
   logic [IW-1:0]  w_off;
   logic [IW:0]    w_sum;

   // Two copies of req side by side; shifting past ptr rotates the scan start to ptr+1.
   assign w_dbl   = {req, req};
   assign w_shift = {1'b0, ptr} + {{IW{1'b0}}, 1'b1};
   assign w_rot   = w_dbl >> w_shift;

   // Lowest set bit of the rotated window is the closest requester after ptr.
   always_comb begin
      valid = 1'b0;
      w_off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            valid = 1'b1;
            w_off = IW'(i);
         end
      end
   end

   // Map the window offset back to an absolute master index.
   always_comb begin
      w_sum = w_shift + {1'b0, w_off};
      idx   = (w_sum >= NW) ? IW'(w_sum - NW) : IW'(w_sum);
   end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with per-grant hold, busy timeout trap and timeout counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner, arbitrate every cycle
// BUSY    | grantee owns bus, watching for done / timeout
// WAIT    | grantee finished but holds bus while dly is high
// FREE    | one dead cycle after release, arbitrate for next owner
// TIMEOUT | grantee stalled too long, bus parked until tout_clr
module rr_bus_arbiter
   import arb_pkg::*;
#(
   parameter int N           = 4,
   parameter int TOUT_CYCLES = TOUT_CYCLES_DEF,
   parameter int CNT_W       = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic                 done,
   input  logic                 dly,
   input  logic                 tout_clr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 bus_busy,
   output logic                 tout,
   output logic [$clog2(N)-1:0] tout_id,
   output logic [CNT_W-1:0]     tout_cnt
);

   localparam int IW = $clog2(N);
   localparam int BW = $clog2(TOUT_CYCLES);
   localparam logic [BW-1:0] BUSY_LAST = BW'(TOUT_CYCLES - 1);

   arb_state_t         r_state, w_state_nxt;
   logic [N-1:0]       r_gnt, w_gnt_nxt;
   logic [IW-1:0]      r_gnt_id, w_gnt_id_nxt;
   logic [IW-1:0]      r_ptr, w_ptr_nxt;
   logic [BW-1:0]      r_busy_cnt, w_busy_cnt_nxt;
   logic [IW-1:0]      r_tout_id, w_tout_id_nxt;
   logic [CNT_W-1:0]   r_tout_cnt, w_tout_cnt_nxt;

   logic               w_pick_valid;
   logic [IW-1:0]      w_pick_idx;

   rr_pick #(.N(N)) u_pick (
      .req   (req),
      .ptr   (r_ptr),
      .valid (w_pick_valid),
      .idx   (w_pick_idx)
   );

   // State and datapath registers; ptr resets to N-1 so master 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_gnt      <= '0;
         r_gnt_id   <= '0;
         r_ptr      <= IW'(N - 1);
         r_busy_cnt <= '0;
         r_tout_id  <= '0;
         r_tout_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_gnt      <= w_gnt_nxt;
         r_gnt_id   <= w_gnt_id_nxt;
         r_ptr      <= w_ptr_nxt;
         r_busy_cnt <= w_busy_cnt_nxt;
         r_tout_id  <= w_tout_id_nxt;
         r_tout_cnt <= w_tout_cnt_nxt;
      end
   end

   // Next-state and next-register logic for the grant lifecycle.
   always_comb begin
      w_state_nxt    = r_state;
      w_gnt_nxt      = r_gnt;
      w_gnt_id_nxt   = r_gnt_id;
      w_ptr_nxt      = r_ptr;
      w_busy_cnt_nxt = r_busy_cnt;
      w_tout_id_nxt  = r_tout_id;
      w_tout_cnt_nxt = r_tout_cnt;

      case (r_state)
         IDLE, FREE: begin
            w_gnt_nxt = '0;
            if (w_pick_valid) begin
               w_state_nxt    = BUSY;
               w_gnt_nxt      = {{(N-1){1'b0}}, 1'b1} << w_pick_idx;
               w_gnt_id_nxt   = w_pick_idx;
               w_ptr_nxt      = w_pick_idx;
               w_busy_cnt_nxt = '0;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         BUSY: begin
            if (done) begin
               if (dly) begin
                  w_state_nxt = WAIT;
               end else begin
                  w_state_nxt = FREE;
                  w_gnt_nxt   = '0;
               end
            end else if (r_busy_cnt == BUSY_LAST) begin
               w_state_nxt   = TIMEOUT;
               w_gnt_nxt     = '0;
               w_tout_id_nxt = r_gnt_id;
               if (r_tout_cnt != {CNT_W{1'b1}}) begin
                  w_tout_cnt_nxt = r_tout_cnt + CNT_W'(1);
               end
            end else begin
               w_busy_cnt_nxt = r_busy_cnt + BW'(1);
            end
         end
         WAIT: begin
            if (!dly) begin
               w_state_nxt = FREE;
               w_gnt_nxt   = '0;
            end
         end
         TIMEOUT: begin
            w_gnt_nxt = '0;
            if (tout_clr) begin
               w_state_nxt = FREE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from registered state only.
   assign gnt      = r_gnt;
   assign gnt_id   = r_gnt_id;
   assign bus_busy = (r_state == BUSY) || (r_state == WAIT);
   assign tout     = (r_state == TIMEOUT);
   assign tout_id  = r_tout_id;
   assign tout_cnt = r_tout_cnt;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against an ownership-level model.
module tb_rr_bus_arbiter;

   localparam int N = 4;
   localparam int T = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic         done = 1'b0;
   logic         dly = 1'b0;
   logic         tout_clr = 1'b0;

   logic [N-1:0] gnt_a, gnt_b;
   logic [1:0]   gnt_id_a, gnt_id_b, tout_id_a, tout_id_b;
   logic         busy_a, busy_b, tout_a, tout_b;
   logic [7:0]   cnt_a;
   logic [1:0]   cnt_b;

   int  checks = 0;
   int  errors = 0;
   bit  chk_en = 1'b0;

   rr_bus_arbiter #(.N(N), .TOUT_CYCLES(T), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done), .dly(dly), .tout_clr(tout_clr),
      .gnt(gnt_a), .gnt_id(gnt_id_a), .bus_busy(busy_a), .tout(tout_a),
      .tout_id(tout_id_a), .tout_cnt(cnt_a)
   );

   rr_bus_arbiter #(.N(N), .TOUT_CYCLES(T), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done), .dly(dly), .tout_clr(tout_clr),
      .gnt(gnt_b), .gnt_id(gnt_id_b), .bus_busy(busy_b), .tout(tout_b),
      .tout_id(tout_id_b), .tout_cnt(cnt_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: who owns the bus, whether it is holding, how long it has stalled,
   // whether the bus is trapped, and the last grantee (lowest priority next).
   int m_owner = -1;
   int m_hold  = 0;
   int m_age   = 0;
   int m_trap  = 0;
   int m_last  = N - 1;
   int m_gid   = 0;
   int m_tid   = 0;
   int m_tcnt  = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner = -1; m_hold = 0; m_age = 0; m_trap = 0;
         m_last = N - 1; m_gid = 0; m_tid = 0; m_tcnt = 0;
      end else if (m_trap != 0) begin
         if (tout_clr) m_trap = 0;
      end else if (m_owner < 0) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (m_owner < 0 && req[c]) begin
               m_owner = c; m_gid = c; m_last = c; m_age = 0; m_hold = 0;
            end
         end
      end else if (m_hold != 0) begin
         if (!dly) begin m_owner = -1; m_hold = 0; end
      end else if (done) begin
         if (dly) m_hold = 1;
         else m_owner = -1;
      end else if (m_age + 1 >= T) begin
         m_trap = 1; m_tid = m_owner; m_tcnt++; m_owner = -1;
      end else begin
         m_age++;
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [31:0] eg;
         eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
         chk("gnt", gnt_a, eg);
         chk("gnt_id", gnt_id_a, m_gid);
         chk("bus_busy", busy_a, (m_owner >= 0) ? 1 : 0);
         chk("tout", tout_a, m_trap);
         chk("tout_id", tout_id_a, m_tid);
         chk("tout_cnt8", cnt_a, (m_tcnt > 255) ? 255 : m_tcnt);
         chk("gnt_b", gnt_b, eg);
         chk("tout_cnt2", cnt_b, (m_tcnt > 3) ? 3 : m_tcnt);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (2) step();
      rst_n  = 1'b1;
      chk_en = 1'b1;
      chk("rst_gnt", gnt_a, 0);
      chk("rst_gnt_id", gnt_id_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_tout_cnt", cnt_a, 0);

      // single master
      req = 4'b0100; step();
      chk("single_gnt", gnt_a, 4'b0100);
      req = '0; step();
      chk("single_busy2", gnt_a, 4'b0100);
      done = 1'b1; step();
      chk("single_free_gnt", gnt_a, 0);
      chk("single_free_busy", busy_a, 0);
      done = 1'b0; step();
      chk("single_idle_gnt", gnt_a, 0);
      chk("single_idle_id", gnt_id_a, 2);

      // round robin from reset
      do_reset();
      req = 4'hF; done = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rr_id", gnt_id_a, i % 4);
         chk("rr_gnt", gnt_a, 1 << (i % 4));
         if (i == 4) req = '0;
         step();
         chk("rr_dead", gnt_a, 0);
      end
      done = 1'b0; step();

      // hold through WAIT
      req = 4'b0010; step();
      chk("hold_gnt", gnt_a, 4'b0010);
      req = '0; done = 1'b1; dly = 1'b1; step();
      chk("wait_gnt", gnt_a, 4'b0010);
      chk("wait_busy", busy_a, 1);
      done = 1'b0;
      repeat (3) begin
         step();
         chk("wait_gnt", gnt_a, 4'b0010);
         chk("wait_busy", busy_a, 1);
      end
      dly = 1'b0; step();
      chk("wait_free", gnt_a, 0);

      // timeout
      req = 4'b0100; step();
      chk("to_gnt", gnt_a, 4'b0100);
      req = '0; step(); step();
      chk("to_busy3", gnt_a, 4'b0100);
      step();
      chk("to_tout", tout_a, 1);
      chk("to_id", tout_id_a, 2);
      chk("to_cnt", cnt_a, 1);
      chk("to_gnt0", gnt_a, 0);
      req = 4'b0101; dly = 1'b1; step();
      chk("to_stay", tout_a, 1);
      tout_clr = 1'b1; dly = 1'b0; step();
      chk("to_clr", tout_a, 0);
      chk("to_free", gnt_a, 0);
      tout_clr = 1'b0; step();
      chk("to_next_id", gnt_id_a, 0);
      chk("to_next_gnt", gnt_a, 4'b0001);
      req = '0; done = 1'b1; step();
      done = 1'b0;

      // counter saturation
      for (int i = 0; i < 4; i++) begin
         req = 4'b0001; step();
         req = '0; repeat (3) step();
         tout_clr = 1'b1; step();
         tout_clr = 1'b0;
      end
      chk("sat_cnt2", cnt_b, 3);
      chk("sat_cnt8", cnt_a, 5);

      // async reset mid-WAIT
      req = 4'b0010; step();
      req = '0; done = 1'b1; dly = 1'b1; step();
      chk("ar_wait", busy_a, 1);
      done = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("ar_gnt", gnt_a, 0);
      chk("ar_busy", busy_a, 0);
      chk("ar_cnt", cnt_a, 0);
      dly = 1'b0; step();
      rst_n = 1'b1; req = 4'b1000; step();
      chk("ar_id3", gnt_id_a, 3);
      req = 4'b1001; done = 1'b1; step();
      chk("ar_dead", gnt_a, 0);
      done = 1'b0; step();
      chk("ar_id0", gnt_id_a, 0);
      req = '0; done = 1'b1; step();
      done = 1'b0;

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         step();
         if (!rst_n) rst_n = 1'b1;
         req      = N'($urandom);
         done     = ($urandom_range(0, 9) < 4);
         dly      = ($urandom_range(0, 9) < 3);
         tout_clr = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 399) == 0) #2 rst_n = 1'b0;
      end
      step();
      rst_n = 1'b1; req = '0; done = 1'b0; dly = 1'b0; tout_clr = 1'b0;
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
